// File: rtl/parking_pkg.sv
// Shared definitions for the gate lane scheduler: one-hot lane states and
// default sizing for the lot capacity, occupancy width and phase timeout.
package parking_pkg;

   typedef enum logic [3:0] {
      LIBRE      = 4'b0001,
      ESPERA_PIN = 4'b0010,
      ABIERTA    = 4'b0100,
      CIERRE     = 4'b1000
   } estado_t;

   localparam int CAPACIDAD_DEF = 8;
   localparam int OCC_W_DEF     = 4;
   localparam int TIMEOUT_DEF   = 15;
   localparam int TIMER_W       = 8;

endpackage

// File: rtl/gate_lane_scheduler_if.sv
// Lane bus between the gate controller and the surrounding lot hardware:
// requests and checker/sensor pulses flow in, grants and lot status flow out.
interface gate_lane_scheduler_if
   import parking_pkg::*;
#(
   parameter int OCC_W = OCC_W_DEF
);

   logic             req_entrada;
   logic             req_salida;
   logic             pin_ok;
   logic             pin_fail;
   logic             sensor_paso;
   logic             grant_entrada;
   logic             grant_salida;
   logic             senal_compuerta;
   logic [OCC_W-1:0] ocupacion;
   logic             lleno;
   logic             senal_alarma_timeout;

   modport master (
      output req_entrada, req_salida, pin_ok, pin_fail, sensor_paso,
      input  grant_entrada, grant_salida, senal_compuerta, ocupacion, lleno,
             senal_alarma_timeout
   );

   modport slave (
      input  req_entrada, req_salida, pin_ok, pin_fail, sensor_paso,
      output grant_entrada, grant_salida, senal_compuerta, ocupacion, lleno,
             senal_alarma_timeout
   );

endinterface

// File: rtl/parking_phase_timer.sv
// Phase timer: counts the cycles spent in a timed phase. The count is zero in
// the first cycle of a phase, so done rises in the TIMEOUT-th cycle.
module parking_phase_timer
   import parking_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam logic [TIMER_W-1:0] ULTIMO = TIMER_W'(TIMEOUT - 1);

   logic [TIMER_W-1:0] cuenta;

   // Clear has priority so every new phase starts counting from zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         cuenta <= '0;
      end else if (clear) begin
         cuenta <= '0;
      end else if (enable) begin
         cuenta <= cuenta + 1'b1;
      end
   end

   assign done = (cuenta == ULTIMO);

endmodule

// File: rtl/gate_lane_scheduler.sv
// Shared-lane gate scheduler: arbitrates entry/exit vehicles round-robin,
// runs the PIN / barrier sequence and keeps the saturating occupancy count.
module gate_lane_scheduler
   import parking_pkg::*;
#(
   parameter int CAPACIDAD = CAPACIDAD_DEF,
   parameter int OCC_W     = OCC_W_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic clock,
   input  logic reset,
   gate_lane_scheduler_if.slave bus
);

   localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACIDAD);

   estado_t          estado, estado_sig;
   logic             lado_entrada, lado_entrada_sig;
   logic             ultimo_entrada, ultimo_entrada_sig;
   logic [OCC_W-1:0] ocupacion, ocupacion_sig;
   logic             alarma, alarma_sig;
   logic             lleno;
   logic             elegible_entrada, elegible_salida;
   logic             timer_clear, timer_enable, timer_done;

   assign lleno            = (ocupacion == CAP);
   assign elegible_entrada = bus.req_entrada && !lleno;
   assign elegible_salida  = bus.req_salida && (ocupacion != '0);

   // The timer only runs while the FSM stays inside a timed phase; any
   // transition (including entry into a timed phase) restarts it.
   assign timer_enable = ((estado == ESPERA_PIN) || (estado == ABIERTA)) &&
                         (estado_sig == estado);
   assign timer_clear  = !timer_enable;

   parking_phase_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (timer_clear),
      .enable (timer_enable),
      .done   (timer_done)
   );

   // State register; reset drops any in-flight count update and closes the gate.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado         <= LIBRE;
         lado_entrada   <= 1'b0;
         ultimo_entrada <= 1'b0;
         ocupacion      <= '0;
         alarma         <= 1'b0;
      end else begin
         estado         <= estado_sig;
         lado_entrada   <= lado_entrada_sig;
         ultimo_entrada <= ultimo_entrada_sig;
         ocupacion      <= ocupacion_sig;
         alarma         <= alarma_sig;
      end
   end

   // Next-state logic: events beat the timeout, pin_fail beats pin_ok.
   always_comb begin
      estado_sig         = estado;
      lado_entrada_sig   = lado_entrada;
      ultimo_entrada_sig = ultimo_entrada;
      ocupacion_sig      = ocupacion;
      alarma_sig         = 1'b0;
      case (estado)
         LIBRE: begin
            if (elegible_entrada && (!elegible_salida || !ultimo_entrada)) begin
               estado_sig       = ESPERA_PIN;
               lado_entrada_sig = 1'b1;
            end else if (elegible_salida) begin
               estado_sig       = ABIERTA;
               lado_entrada_sig = 1'b0;
            end
         end
         ESPERA_PIN: begin
            if (bus.pin_fail) begin
               estado_sig = CIERRE;
            end else if (bus.pin_ok) begin
               estado_sig = ABIERTA;
            end else if (timer_done) begin
               estado_sig = CIERRE;
               alarma_sig = 1'b1;
            end
         end
         ABIERTA: begin
            if (bus.sensor_paso) begin
               estado_sig = CIERRE;
               if (lado_entrada) begin
                  if (ocupacion != CAP) begin
                     ocupacion_sig = ocupacion + 1'b1;
                  end
               end else begin
                  if (ocupacion != '0) begin
                     ocupacion_sig = ocupacion - 1'b1;
                  end
               end
            end else if (timer_done) begin
               estado_sig = CIERRE;
               alarma_sig = 1'b1;
            end
         end
         CIERRE: begin
            estado_sig         = LIBRE;
            ultimo_entrada_sig = lado_entrada;
         end
         default: begin
            estado_sig = LIBRE;
         end
      endcase
   end

   assign bus.grant_entrada        = (estado != LIBRE) && lado_entrada;
   assign bus.grant_salida         = (estado != LIBRE) && !lado_entrada;
   assign bus.senal_compuerta      = (estado == ABIERTA);
   assign bus.ocupacion            = ocupacion;
   assign bus.lleno                = lleno;
   assign bus.senal_alarma_timeout = alarma;

endmodule

// File: tb/tb_gate_lane_scheduler.sv
// Self-checking bench for gate_lane_scheduler: directed lane scenarios followed
// by random traffic, every cycle compared against a transaction-level model.
module tb_gate_lane_scheduler;

   localparam int CAP     = 8;
   localparam int TIMEOUT = 15;

   localparam int P_IDLE  = 0;
   localparam int P_PIN   = 1;
   localparam int P_OPEN  = 2;
   localparam int P_CLOSE = 3;

   logic clock;
   logic reset;
   int   total;
   int   bad;
   int   cycle;
   int   open_cycles;

   int   m_phase;
   int   m_in_phase;
   bit   m_entry_side;
   bit   m_last_entry;
   int   m_occ;
   bit   m_alarm;

   gate_lane_scheduler_if #(.OCC_W(4)) bus ();

   gate_lane_scheduler #(
      .CAPACIDAD (CAP),
      .OCC_W     (4),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, obs, exp);
      end
   endtask

   task automatic modelStep(input bit re, input bit rs, input bit ok, input bit fail,
                            input bit paso, input bit rst);
      int  n;
      bit  ent;
      bit  sal;
      if (rst) begin
         m_phase      = P_IDLE;
         m_in_phase   = 0;
         m_entry_side = 1'b0;
         m_last_entry = 1'b0;
         m_occ        = 0;
         m_alarm      = 1'b0;
         return;
      end
      n       = m_in_phase + 1;
      m_alarm = 1'b0;
      case (m_phase)
         P_IDLE: begin
            ent = re && (m_occ < CAP);
            sal = rs && (m_occ > 0);
            if (ent && (!sal || !m_last_entry)) begin
               m_phase = P_PIN; m_entry_side = 1'b1; m_in_phase = 0;
            end else if (sal) begin
               m_phase = P_OPEN; m_entry_side = 1'b0; m_in_phase = 0;
            end
         end
         P_PIN: begin
            if (fail) begin
               m_phase = P_CLOSE;
            end else if (ok) begin
               m_phase = P_OPEN; m_in_phase = 0;
            end else if (n == TIMEOUT) begin
               m_phase = P_CLOSE; m_alarm = 1'b1;
            end else begin
               m_in_phase = n;
            end
         end
         P_OPEN: begin
            if (paso) begin
               m_phase = P_CLOSE;
               if (m_entry_side) m_occ = (m_occ + 1 > CAP) ? CAP : m_occ + 1;
               else              m_occ = (m_occ - 1 < 0) ? 0 : m_occ - 1;
            end else if (n == TIMEOUT) begin
               m_phase = P_CLOSE; m_alarm = 1'b1;
            end else begin
               m_in_phase = n;
            end
         end
         default: begin
            m_phase      = P_IDLE;
            m_in_phase   = 0;
            m_last_entry = m_entry_side;
         end
      endcase
   endtask

   task automatic applyStimulus(input bit re, input bit rs, input bit ok, input bit fail,
                                input bit paso, input bit rst);
      @(negedge clock);
      bus.req_entrada = re;
      bus.req_salida  = rs;
      bus.pin_ok      = ok;
      bus.pin_fail    = fail;
      bus.sensor_paso = paso;
      reset           = rst;
      @(posedge clock);
      modelStep(re, rs, ok, fail, paso, rst);
      #1;
      cycle++;
      checkOutput("grant_entrada", bus.grant_entrada, (m_phase != P_IDLE) && m_entry_side);
      checkOutput("grant_salida", bus.grant_salida, (m_phase != P_IDLE) && !m_entry_side);
      checkOutput("senal_compuerta", bus.senal_compuerta, m_phase == P_OPEN);
      checkOutput("ocupacion", bus.ocupacion, m_occ);
      checkOutput("lleno", bus.lleno, m_occ == CAP);
      checkOutput("alarma", bus.senal_alarma_timeout, m_alarm);
      if (bus.senal_compuerta === 1'b1) open_cycles++;
   endtask

   task automatic entryTxn();
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic exitTxn();
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   // Directed scenarios first, then random traffic, then the summary.
   initial begin
      total = 0; bad = 0; cycle = 0; open_cycles = 0;
      reset = 1'b1;
      bus.req_entrada = 0; bus.req_salida = 0; bus.pin_ok = 0;
      bus.pin_fail = 0; bus.sensor_paso = 0;

      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("reset_grant", {bus.grant_entrada, bus.grant_salida}, 0);
      checkOutput("reset_occ", bus.ocupacion, 0);

      // Entry happy path: grant after one cycle, pin_ok 3 cycles later, gate open 2 cycles.
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("happy_grant", bus.grant_entrada, 1);
      open_cycles = 0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("happy_open_cycles", open_cycles, 2);
      checkOutput("happy_occ", bus.ocupacion, 1);
      checkOutput("happy_idle", bus.grant_entrada, 0);

      // PIN timeout while waiting.
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < TIMEOUT; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("pin_timeout_alarm", bus.senal_alarma_timeout, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Round robin with exit served last: entry wins, then exit.
      entryTxn();
      entryTxn();
      exitTxn();
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("rr_first_entry", {bus.grant_entrada, bus.grant_salida}, 2);
      applyStimulus(1, 1, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 1, 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("rr_second_exit", {bus.grant_entrada, bus.grant_salida}, 1);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rr_occ", bus.ocupacion, 2);

      // Full lot: entry ignored, exit served.
      for (int i = 0; i < 6; i++) entryTxn();
      checkOutput("full_lleno", bus.lleno, 1);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("full_no_grant", bus.grant_entrada, 0);
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("full_exit_grant", bus.grant_salida, 1);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("full_occ", bus.ocupacion, 7);

      // pin_ok with pin_fail together acts as a failure.
      open_cycles = 0;
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkOutput("both_pin_cierre_grant", bus.grant_entrada, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("both_pin_idle", bus.grant_entrada, 0);
      checkOutput("both_pin_never_open", open_cycles, 0);
      checkOutput("both_pin_occ", bus.ocupacion, 7);

      // Barrier timeout, then a sensor pulse in the last allowed cycle.
      applyStimulus(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("to_still_open", bus.senal_compuerta, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("to_alarm", {bus.senal_alarma_timeout, bus.senal_compuerta}, 2);
      checkOutput("to_occ", bus.ocupacion, 7);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("to_alarm_pulse", bus.senal_alarma_timeout, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("late_paso_no_alarm", bus.senal_alarma_timeout, 0);
      checkOutput("late_paso_occ", bus.ocupacion, 6);
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Reset while open with a sensor pulse: everything clears.
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("rst_open_outputs",
                  {bus.grant_entrada, bus.grant_salida, bus.senal_compuerta,
                   bus.senal_alarma_timeout}, 0);
      checkOutput("rst_open_occ", bus.ocupacion, 0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gate_lane_scheduler.md
GATE_LANE_SCHEDULER -- requirements
Module: gate_lane_scheduler

Interface
REQ-001 Parameter CAPACIDAD, default 8: maximum vehicles inside the lot; legal range 1..(2^OCC_W - 1).
REQ-002 Parameter OCC_W, default 4: width of the occupancy count.
REQ-003 Parameter TIMEOUT, default 15: cycles allowed per transaction phase; legal range 1..255.
REQ-004 clock  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_entrada  in  1  level: a vehicle is waiting at the entry side of the shared lane.
REQ-007 req_salida  in  1  level: a vehicle is waiting at the exit side of the shared lane.
REQ-008 pin_ok  in  1  single-cycle pulse: the external PIN checker accepted the code.
REQ-009 pin_fail  in  1  single-cycle pulse: the external PIN checker rejected the code.
REQ-010 sensor_paso  in  1  single-cycle pulse: the vehicle has cleared the barrier.
REQ-011 grant_entrada  out  1  the entry side owns the lane.
REQ-012 grant_salida  out  1  the exit side owns the lane.
REQ-013 senal_compuerta  out  1  the barrier is open.
REQ-014 ocupacion  out  OCC_W  current vehicle count.
REQ-015 lleno  out  1  high when ocupacion == CAPACIDAD.
REQ-016 senal_alarma_timeout  out  1  one-cycle pulse when a phase times out.

Function
REQ-017 The FSM SHALL have four one-hot states: LIBRE, ESPERA_PIN, ABIERTA and CIERRE.
REQ-018 In LIBRE, an eligible request SHALL grant on the next edge: entry goes to ESPERA_PIN, exit goes directly to ABIERTA.
REQ-019 Eligibility: entry is eligible only when !lleno; exit is eligible only when ocupacion != 0; an ineligible request SHALL be ignored.
REQ-020 If both sides are eligible in the same cycle, the grant SHALL go to the side not served last (round-robin); after reset the entry side wins.
REQ-021 grant_entrada and grant_salida SHALL be Moore outputs, mutually exclusive, and held from the grant through CIERRE inclusive.
REQ-022 In ESPERA_PIN, pin_ok SHALL move the FSM to ABIERTA, and pin_fail SHALL move it to CIERRE with the barrier kept closed.
REQ-023 If pin_ok and pin_fail arrive together, the event SHALL be treated as pin_fail.
REQ-024 pin_ok and pin_fail SHALL be ignored in every state other than ESPERA_PIN.
REQ-025 senal_compuerta SHALL be high exactly while the FSM is in ABIERTA.
REQ-026 sensor_paso in ABIERTA SHALL update ocupacion on the same edge as the exit to CIERRE: +1 for entry, -1 for exit.
REQ-027 The ocupacion update SHALL saturate at CAPACIDAD and at 0.
REQ-028 sensor_paso SHALL be ignored outside ABIERTA.
REQ-029 A phase timer SHALL clear on every entry to ESPERA_PIN or ABIERTA and increment each cycle the FSM stays there.
REQ-030 When the phase timer reaches TIMEOUT with no qualifying event, the FSM SHALL go to CIERRE, pulse senal_alarma_timeout for one cycle, and leave ocupacion unchanged.
REQ-031 A qualifying event that arrives in the same cycle as the timeout SHALL win over the timeout.
REQ-032 CIERRE SHALL last exactly one cycle, return to LIBRE, and record the served side for round-robin.
REQ-033 A request that drops mid-transaction SHALL NOT abort the transaction; only events or the timeout advance the FSM.
REQ-034 lleno SHALL be combinational from ocupacion.

Reset
REQ-035 On reset: state LIBRE, all grants 0, senal_compuerta 0, senal_alarma_timeout 0, ocupacion 0, timer 0, last-served set to exit.
REQ-036 Reset asserted mid-transaction SHALL close the barrier on the next edge and discard the in-flight count update.

Structure
REQ-037 The state encodings and the default values of CAPACIDAD and TIMEOUT SHALL live in a shared package, parking_pkg.
REQ-038 The phase timer (clear, enable, terminal-count flag) SHALL be a sub-module, parking_phase_timer.

Verification
REQ-039 Entry happy path: req_entrada=1 at ocupacion=0; pin_ok 3 cycles later; sensor_paso 2 cycles after that -> grant_entrada 1 cycle after the request, barrier open for 2 cycles, ocupacion=1, back in LIBRE.
REQ-040 Simultaneous requests after reset with ocupacion=2 -> entry is served first, exit second; ocupacion returns to 2.
REQ-041 Full lot: ocupacion=8 and req_entrada held -> no grant; a concurrent req_salida is granted and ocupacion becomes 7.
REQ-042 pin_fail and pin_ok in the same cycle -> barrier never opens, ocupacion unchanged, FSM goes to CIERRE then LIBRE.
REQ-043 No sensor_paso for 15 cycles in ABIERTA -> one-cycle senal_alarma_timeout pulse, barrier closes, ocupacion unchanged; a sensor_paso in cycle 15 counts normally with no alarm.
REQ-044 Reset asserted while in ABIERTA with sensor_paso in the same cycle -> next cycle all outputs 0, ocupacion=0.
